// File: rtl/timer_master_pkg.sv
// Shared encodings for the timer master: op codes, timer register map,
// control bit positions, FSM states and the bus payload struct.
package timer_master_pkg;

  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned PERIOD_W = 32;
  localparam int unsigned RSP_W    = 32;
  localparam int unsigned TICK_W   = 16;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_STOP  = 2'd1,
    OP_SNAP  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  // Timer register word addresses
  localparam logic [ADDR_W-1:0] REG_STATUS   = 3'd0;
  localparam logic [ADDR_W-1:0] REG_CONTROL  = 3'd1;
  localparam logic [ADDR_W-1:0] REG_PERIOD_L = 3'd2;
  localparam logic [ADDR_W-1:0] REG_PERIOD_H = 3'd3;
  localparam logic [ADDR_W-1:0] REG_SNAP_L   = 3'd4;
  localparam logic [ADDR_W-1:0] REG_SNAP_H   = 3'd5;

  localparam int unsigned CTRL_STOP_BIT  = 3;
  localparam int unsigned CTRL_START_BIT = 2;
  localparam int unsigned CTRL_CONT_BIT  = 1;
  localparam int unsigned CTRL_ITO_BIT   = 0;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    WR_PL   = 4'd1,
    WR_PH   = 4'd2,
    WR_CTRL = 4'd3,
    WR_SNAP = 4'd4,
    RD_SL   = 4'd5,
    RD_SH   = 4'd6,
    CAP_SH  = 4'd7,
    WR_STAT = 4'd8,
    RESP    = 4'd9
`ifdef TIMER_MASTER_IRQ_SVC_EN
    ,
    IRQ_SVC = 4'd10
`endif
  } state_e;

  typedef struct packed {
    logic              chipselect;
    logic              write_n;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
  } bus_t;

  localparam bus_t BUS_IDLE = '{chipselect: 1'b0, write_n: 1'b1, address: '0, writedata: '0};

  function automatic bus_t bus_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    bus_t b;
    b.chipselect = 1'b1;
    b.write_n    = 1'b0;
    b.address    = addr;
    b.writedata  = data;
    return b;
  endfunction

  function automatic bus_t bus_read(input logic [ADDR_W-1:0] addr);
    bus_t b;
    b.chipselect = 1'b1;
    b.write_n    = 1'b1;
    b.address    = addr;
    b.writedata  = '0;
    return b;
  endfunction

  function automatic logic [DATA_W-1:0] ctrl_word(input logic stop, input logic start,
                                                  input logic cont, input logic ito);
    logic [DATA_W-1:0] w;
    w                 = '0;
    w[CTRL_STOP_BIT]  = stop;
    w[CTRL_START_BIT] = start;
    w[CTRL_CONT_BIT]  = cont;
    w[CTRL_ITO_BIT]   = ito;
    return w;
  endfunction

endpackage

// File: rtl/timer_master.sv
// Timer master: turns START/STOP/SNAP/CLEAR commands into single-cycle timer
// register transfers. Define TIMER_MASTER_IRQ_SVC_EN to service the timer irq.
module timer_master
  import timer_master_pkg::*;
#(
  parameter logic CONT_MODE  = 1'b1,
  parameter logic IRQ_ENABLE = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [PERIOD_W-1:0] cmd_period,
  output logic                rsp_valid,
  output logic [RSP_W-1:0]    rsp_data,
  input  logic                irq,
  output logic [TICK_W-1:0]   tick_count,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_chipselect,
  output logic                m_write_n,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic [DATA_W-1:0]   m_readdata
);

  state_e              state_q, state_d;
  op_e                 op_q, op_sel;
  logic [PERIOD_W-1:0] period_q, period_sel;
  logic [DATA_W-1:0]   snap_lo_q, snap_lo_d;
  bus_t                bus_q, bus_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [RSP_W-1:0]    rsp_data_q, rsp_data_d;
  logic                accept;

  // Handshake is combinational so a same-cycle irq can win over a command
`ifdef TIMER_MASTER_IRQ_SVC_EN
  assign cmd_ready = (state_q == IDLE) && !irq;
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign cmd_ready  = (state_q == IDLE);
`endif

  assign accept     = cmd_valid && cmd_ready;
  assign op_sel     = accept ? op_e'(cmd_op) : op_q;
  assign period_sel = accept ? cmd_period : period_q;

  // Next state, then the registered bus/response for the state being entered
  always_comb begin
    state_d     = state_q;
    snap_lo_d   = snap_lo_q;
    bus_d       = BUS_IDLE;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      IDLE: begin
`ifdef TIMER_MASTER_IRQ_SVC_EN
        if (irq) state_d = IRQ_SVC;
        else
`endif
        if (accept) begin
          case (op_sel)
            OP_START: state_d = WR_PL;
            OP_STOP:  state_d = WR_CTRL;
            OP_SNAP:  state_d = WR_SNAP;
            OP_CLEAR: state_d = WR_STAT;
            default:  state_d = IDLE;
          endcase
        end
      end
      WR_PL:   state_d = WR_PH;
      WR_PH:   state_d = WR_CTRL;
      WR_CTRL: state_d = RESP;
      WR_SNAP: state_d = RD_SL;
      RD_SL:   state_d = RD_SH;
      RD_SH: begin
        // read data for the SNAP_L read is valid during this cycle
        state_d   = CAP_SH;
        snap_lo_d = m_readdata;
      end
      CAP_SH:  state_d = RESP;
      WR_STAT: state_d = RESP;
`ifdef TIMER_MASTER_IRQ_SVC_EN
      IRQ_SVC: state_d = IDLE;
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      WR_PL:   bus_d = bus_write(REG_PERIOD_L, period_sel[DATA_W-1:0]);
      WR_PH:   bus_d = bus_write(REG_PERIOD_H, period_sel[PERIOD_W-1:DATA_W]);
      WR_CTRL: begin
        if (op_sel == OP_STOP)
          bus_d = bus_write(REG_CONTROL, ctrl_word(1'b1, 1'b0, CONT_MODE, IRQ_ENABLE));
        else
          bus_d = bus_write(REG_CONTROL, ctrl_word(1'b0, 1'b1, CONT_MODE, IRQ_ENABLE));
      end
      WR_SNAP: bus_d = bus_write(REG_SNAP_L, '0);
      RD_SL:   bus_d = bus_read(REG_SNAP_L);
      RD_SH:   bus_d = bus_read(REG_SNAP_H);
      WR_STAT: bus_d = bus_write(REG_STATUS, '0);
`ifdef TIMER_MASTER_IRQ_SVC_EN
      IRQ_SVC: bus_d = bus_write(REG_STATUS, '0);
`endif
      RESP: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = (op_sel == OP_SNAP) ? {m_readdata, snap_lo_q} : '0;
      end
      default: bus_d = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_START;
      period_q    <= '0;
      snap_lo_q   <= '0;
      bus_q       <= BUS_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_sel;
      period_q    <= period_sel;
      snap_lo_q   <= snap_lo_d;
      bus_q       <= bus_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef TIMER_MASTER_IRQ_SVC_EN
  logic [TICK_W-1:0] tick_q;

  // Counts serviced interrupts, wrapping naturally at the counter width
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     tick_q <= '0;
    else if (state_d == IRQ_SVC)   tick_q <= tick_q + TICK_W'(1);
  end

  assign tick_count = tick_q;
`else
  assign tick_count = '0;
`endif

  assign m_chipselect = bus_q.chipselect;
  assign m_write_n    = bus_q.write_n;
  assign m_address    = bus_q.address;
  assign m_writedata  = bus_q.writedata;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_timer_master.sv
// Randomized bench for timer_master: a transaction-level model lists the bus
// transfers and response each command must produce, cycle by cycle.
module tb_timer_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_period;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        irq;
  logic [15:0] tick_count;
  logic [2:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_tick = '0;

  timer_master dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_period   (cmd_period),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .irq          (irq),
    .tick_count   (tick_count),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of bus activity: {cs, write_n, addr, wdata, rsp_valid}
  function automatic logic [21:0] xfer(input logic cs, input logic wn, input logic [2:0] a,
                                       input logic [15:0] d, input logic rv);
    return {cs, wn, a, d, rv};
  endfunction

  function automatic logic [21:0] wr(input logic [2:0] a, input logic [15:0] d);
    return xfer(1'b1, 1'b0, a, d, 1'b0);
  endfunction

  function automatic logic [21:0] rd(input logic [2:0] a);
    return xfer(1'b1, 1'b1, a, 16'h0, 1'b0);
  endfunction

  function automatic logic [21:0] idle_cyc();
    return xfer(1'b0, 1'b1, 3'd0, 16'h0, 1'b0);
  endfunction

  function automatic logic [21:0] resp_cyc();
    return xfer(1'b0, 1'b1, 3'd0, 16'h0, 1'b1);
  endfunction

  function automatic logic [21:0] observed();
    return {m_chipselect, m_write_n, m_address, m_writedata, rsp_valid};
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [31:0] period,
                         input logic [15:0] lo, input logic [15:0] hi, input logic with_irq);
    logic [21:0] exp_q[$];
    logic [31:0] exp_rsp;
    int          wait_n;
    logic        prev_rd;
    logic [2:0]  prev_addr;

    exp_rsp = '0;
    case (op)
      2'd0: exp_q = {wr(3'd2, period[15:0]), wr(3'd3, period[31:16]), wr(3'd1, 16'h0007)};
      2'd1: exp_q = {wr(3'd1, 16'h000B)};
      2'd2: begin
        exp_q   = {wr(3'd4, 16'h0), rd(3'd4), rd(3'd5), idle_cyc()};
        exp_rsp = {hi, lo};
      end
      default: exp_q = {wr(3'd0, 16'h0)};
    endcase
    exp_q.push_back(resp_cyc());

    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_period = period;
`ifndef TIMER_MASTER_IRQ_SVC_EN
    irq = with_irq;
`endif
    #1;
    wait_n = 0;
    while (!cmd_ready && wait_n < 50) begin
      tick();
      wait_n++;
    end
    check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid  = 1'b0;
    cmd_op     = 2'($urandom);
    cmd_period = $urandom;

    prev_rd   = 1'b0;
    prev_addr = 3'd0;
    foreach (exp_q[k]) begin
      // registered slave: data for a read appears the cycle after it
      m_readdata = prev_rd ? ((prev_addr == 3'd4) ? lo : hi) : 16'($urandom);
      check($sformatf("bus_op%0d_c%0d", op, k + 1), 64'(observed()), 64'(exp_q[k]));
      if (k == exp_q.size() - 1)
        check($sformatf("rsp_data_op%0d", op), 64'(rsp_data), 64'(exp_rsp));
      prev_rd   = m_chipselect && m_write_n;
      prev_addr = m_address;
`ifdef TIMER_MASTER_IRQ_SVC_EN
      if (with_irq && k == 0) irq = 1'b1;
`endif
      tick();
    end

    m_readdata = '0;
    check("post_idle", 64'(observed()), 64'(idle_cyc()));
    check("rsp_data_hold", 64'(rsp_data), 64'(exp_rsp));
`ifdef TIMER_MASTER_IRQ_SVC_EN
    if (with_irq) begin
      check("irq_deferred_ready", 64'(cmd_ready), 64'(0));
      tick();
      exp_tick++;
      check("irq_svc_bus", 64'(observed()), 64'(wr(3'd0, 16'h0)));
      check("irq_svc_tick", 64'(tick_count), 64'(exp_tick));
      irq = 1'b0;
      tick();
    end
`else
    irq = 1'b0;
    check("tick_tied", 64'(tick_count), 64'(exp_tick));
`endif
    check("ready_after", 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    int seen;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 2'd0;
    cmd_period = '0;
    irq        = 1'b0;
    m_readdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus", 64'(observed()), 64'(idle_cyc()));
    check("rst_ready", 64'(cmd_ready), 64'(1));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_tick", 64'(tick_count), 64'(0));
    reset = 1'b0;
    tick();

    run_cmd(2'd0, 32'h0001_E847, 16'h0, 16'h0, 1'b0);
    run_cmd(2'd2, 32'h0, 16'h1234, 16'hABCD, 1'b0);
    run_cmd(2'd1, 32'hFFFF_FFFF, 16'h0, 16'h0, 1'b0);
    run_cmd(2'd3, 32'h0, 16'h0, 16'h0, 1'b0);

`ifdef TIMER_MASTER_IRQ_SVC_EN
    // irq and command together: interrupt is serviced first
    irq        = 1'b1;
    cmd_valid  = 1'b1;
    cmd_op     = 2'd0;
    cmd_period = 32'h1234_5678;
    #1;
    check("irq_prio_ready", 64'(cmd_ready), 64'(0));
    tick();
    exp_tick++;
    check("irq_prio_bus", 64'(observed()), 64'(wr(3'd0, 16'h0)));
    check("irq_prio_tick", 64'(tick_count), 64'(exp_tick));
    irq = 1'b0;
    tick();
    check("irq_prio_ready_after", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0;
    check("irq_prio_cmd", 64'(observed()), 64'(wr(3'd2, 16'h5678)));
    repeat (3) tick();
    check("irq_prio_resp", 64'(observed()), 64'(resp_cyc()));
    tick();

    // level irq held: one service per IDLE/IRQ_SVC pair
    irq = 1'b1;
    repeat (8) tick();
    irq = 1'b0;
    exp_tick = exp_tick + 16'd4;
    check("irq_held_count", 64'(tick_count), 64'(exp_tick));
    tick();

    force dut.tick_q = 16'hFFFF;
    #1;
    release dut.tick_q;
    exp_tick = 16'hFFFF;
    irq = 1'b1;
    tick();
    irq = 1'b0;
    exp_tick++;
    check("tick_wrap", 64'(tick_count), 64'(exp_tick));
    tick();
`endif

    for (int i = 0; i < 30; i++)
      run_cmd(2'($urandom), $urandom, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

    // reset in the middle of a START
    run_cmd(2'd2, 32'h0, 16'h5A5A, 16'hC3C3, 1'b0);
    cmd_valid  = 1'b1;
    cmd_op     = 2'd0;
    cmd_period = 32'hCAFE_BEEF;
    #1;
    check("mid_pre_ready", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0;
    check("mid_wr_pl", 64'(observed()), 64'(wr(3'd2, 16'hBEEF)));
    tick();
    check("mid_wr_ph", 64'(observed()), 64'(wr(3'd3, 16'hCAFE)));
    reset = 1'b1;
    tick();
    check("mid_rst_bus", 64'(observed()), 64'(idle_cyc()));
    check("mid_rst_ready", 64'(cmd_ready), 64'(1));
    check("mid_rst_rsp_data", 64'(rsp_data), 64'(0));
    check("mid_rst_tick", 64'(tick_count), 64'(0));
    reset = 1'b0;
    seen  = 0;
    repeat (8) begin
      tick();
      if (rsp_valid || m_chipselect) seen++;
    end
    check("mid_no_resume", 64'(seen), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_master.md
TIMER_MASTER -- requirements
Module: timer_master

Interface
REQ-001 CONT_MODE, 1, value driven on control bit 1 (continuous) in every control write.
REQ-002 IRQ_ENABLE, 1, value driven on control bit 0 (interrupt enable) in every control write.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_op  input  2  0=START, 1=STOP, 2=SNAP, 3=CLEAR.
REQ-008 cmd_period  input  32  period value for START.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_data  output  32  snapshot for SNAP, 0 otherwise.
REQ-011 irq  input  1  timer interrupt, level.
REQ-012 tick_count  output  16  serviced-interrupt count.
REQ-013 m_address  output  3  timer register word address.
REQ-014 m_chipselect  output  1  bus access strobe.
REQ-015 m_write_n  output  1  0=write, 1=read.
REQ-016 m_writedata  output  16  write data.
REQ-017 m_readdata  input  16  registered read data, valid the cycle after a read cycle.

Function
REQ-018 Bus access SHALL be one cycle per transfer with no wait states; idle bus: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
REQ-019 States: IDLE, WR_PL, WR_PH, WR_CTRL, WR_SNAP, RD_SL, RD_SH, CAP_SH, WR_STAT, IRQ_SVC, RESP.
REQ-020 cmd_ready SHALL be 1 only in IDLE with no pending interrupt service (REQ-027).
REQ-021 START: WR_PL (addr 2, period[15:0]) -> WR_PH (addr 3, period[31:16]) -> WR_CTRL (addr 1, {0,1,CONT_MODE,IRQ_ENABLE}) -> RESP.
REQ-022 STOP: WR_CTRL (addr 1, {1,0,CONT_MODE,IRQ_ENABLE}) -> RESP.
REQ-023 SNAP: WR_SNAP (addr 4, data 0) -> RD_SL (read addr 4) -> RD_SH (read addr 5, capture m_readdata as low half) -> CAP_SH (capture high half) -> RESP.
REQ-024 CLEAR: WR_STAT (addr 0, data 0) -> RESP.
REQ-025 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE; accepted-to-rsp_valid latency: START 4, STOP 2, SNAP 5, CLEAR 2 cycles.
REQ-026 cmd_period and cmd_op SHALL be latched on acceptance; later input changes SHALL have no effect on the sequence in flight.
REQ-027 In IDLE, irq=1 SHALL take priority over cmd_valid and enter IRQ_SVC: write addr 0 (data 0), increment tick_count, return to IDLE.
REQ-028 tick_count SHALL wrap 0xFFFF -> 0x0000.
REQ-029 irq asserting outside IDLE SHALL be deferred until IDLE; no interrupt SHALL be lost while irq stays asserted.
REQ-030 rsp_data SHALL hold its value until the next RESP.

Reset
REQ-031 Assertion of reset at any cycle, including mid-sequence, SHALL force state IDLE, the idle bus values of REQ-018, and cmd_ready=1, rsp_valid=0, rsp_data=0, tick_count=0.
REQ-032 An interrupted sequence SHALL NOT resume and SHALL NOT produce rsp_valid.

Configuration
REQ-033 Macro TIMER_MASTER_IRQ_SVC_EN defined: REQ-027..029 active.
REQ-034 Macro undefined: irq ignored, IRQ_SVC not present, tick_count tied to 0, cmd_ready depends on state only.

Structure
REQ-035 Package timer_master_pkg SHALL hold op encodings, register address constants (STATUS=0, CONTROL=1, PERIOD_L=2, PERIOD_H=3, SNAP_L=4, SNAP_H=5), control bit positions (STOP=3, START=2, CONT=1, ITO=0) and the state enum.
REQ-036 Single module; no sub-module.

Verification
REQ-037 START with period 0x0001_E847 -> bus writes addr2=0xE847, addr3=0x0001, addr1=0x7 on consecutive cycles, rsp_valid 4 cycles after acceptance.
REQ-038 SNAP with m_readdata=0x1234 then 0xABCD on the cycles after the two reads -> rsp_data=0xABCD_1234, rsp_valid 5 cycles after acceptance.
REQ-039 irq=1 and cmd_valid=1 simultaneously in IDLE -> status write (addr 0) first, tick_count 0->1, command accepted afterwards.
REQ-040 tick_count=0xFFFF plus one serviced irq -> tick_count=0x0000.
REQ-041 reset asserted during WR_PH of START -> next cycle bus idle, no rsp_valid, cmd_ready=1, tick_count=0.
